pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first PC issued after reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  advance enable; 0 = stall, all state and outputs hold.
REQ-005 instr_valid  input  1  instr holds the word fetched at the current pc.
REQ-006 instr  input  32  fetched instruction: opcode [31:26], jump index [25:0], branch imm [15:0].
REQ-007 cond_valid  input  1  branch-condition result is present this cycle.
REQ-008 cond_zero  input  1  ALU zero flag; sampled only when cond_valid=1.
REQ-009 pc  output  32  current fetch address, registered.
REQ-010 pc_valid  output  1  pc is a valid fetch address this cycle.
REQ-011 flush  output  1  one-cycle pulse: discard the instruction fetched after a redirect.
REQ-012 busy  output  1  high while in S_RESOLVE.

Function
REQ-013 States: S_BOOT, S_RUN and S_RESOLVE; encoding is free.
REQ-014 pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-015 Jump target = {pc_plus4[31:28], instr[25:0], 2'b00}; the 28-bit low field is the 26-bit index shifted left by 2.
REQ-016 Branch target = pc_plus4 + {sign-extended instr[15:0], 2'b00}, modulo 2^32.
REQ-017 S_BOOT lasts one cycle with pc = RESET_VECTOR and pc_valid = 0, then goes to S_RUN regardless of en.
REQ-018 In S_RUN, pc_valid = 1.
REQ-019 S_RUN with en=1 and instr_valid=0: pc <= pc_plus4.
REQ-020 S_RUN with en=1, instr_valid=1 and opcode 6'b000010 (J) or 6'b000011 (JAL): pc <= jump target and flush = 1 in the next cycle.
REQ-021 S_RUN with en=1, instr_valid=1 and opcode 6'b000100 (BEQ) or 6'b000101 (BNE): latch opcode and branch target, hold pc, go to S_RESOLVE.
REQ-022 S_RUN with en=1, instr_valid=1 and any other opcode: pc <= pc_plus4.
REQ-023 In S_RESOLVE: pc holds, pc_valid = 0, busy = 1.
REQ-024 S_RESOLVE with en=1 and cond_valid=1: taken = cond_zero for BEQ, ~cond_zero for BNE.
REQ-025 If taken, pc <= latched target and flush = 1 in the next cycle; otherwise pc <= pc_plus4 with no flush. Either way, go to S_RUN.
REQ-026 cond_valid is ignored outside S_RESOLVE, and whenever en=0.
REQ-027 en=0 in any state except S_BOOT freezes state, pc and latched target.
REQ-028 flush is not re-asserted while stalled; it deasserts after its single active clock.
REQ-029 Redirect latency: the target appears on pc exactly one enabled edge after the deciding cycle.

Reset
REQ-030 On rst_n=0, immediately and asynchronously: state = S_BOOT, pc = RESET_VECTOR, pc_valid = 0, flush = 0, busy = 0, latched target = 0, link outputs = 0.
REQ-031 Reset asserted mid-S_RESOLVE abandons the pending branch; no redirect follows the reset release.
REQ-032 After rst_n rises, the first edge completes S_BOOT.

Configuration
REQ-033 Macro PC_SEQ_JAL_LINK_EN is defined: add outputs link_we (1) and link_data (32).
REQ-034 With the macro, on the JAL decision edge, link_we pulses for one cycle and link_data = pc_plus4 of the JAL.
REQ-035 With the macro, link_data holds until the next JAL.
REQ-036 Without the macro, the link ports and logic are absent, and JAL behaves identically to J.

Verification
REQ-037 Reset release, en=1, no valid instr for 4 cycles -> pc sequence 0 (pc_valid=0), 0, 4, 8, 12.
REQ-038 pc=32'h1000_0008, J with index 26'h000_0040 -> next pc = 32'h1000_0100, flush=1 for exactly one cycle.
REQ-039 pc=32'h0000_0020, BEQ with imm=16'hFFFE -> busy=1, pc holds for 3 cycles of cond_valid=0.
REQ-040 Continuing REQ-039: cond_valid=1 with cond_zero=1 -> pc = 32'h0000_001C, flush=1; a repeat with cond_zero=0 -> pc = 32'h0000_0024, no flush.
REQ-041 BNE pending, en=0 with cond_valid=1 -> no change; then rst_n pulsed low -> pc = RESET_VECTOR asynchronously, state = S_BOOT.
REQ-042 PC_SEQ_JAL_LINK_EN defined, JAL at pc=32'h0000_0040 -> link_we one cycle, link_data = 32'h0000_0044.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with jump redirect and two-phase
// branch resolution. Optional JAL link write-back is enabled by defining
// PC_SEQ_JAL_LINK_EN (adds link_we / link_data outputs).
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        cond_valid,
    input  logic        cond_zero,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        busy
`ifdef PC_SEQ_JAL_LINK_EN
    ,
    output logic        link_we,
    output logic [31:0] link_data
`endif
);

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_RESOLVE
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic        r_is_bne;
    logic        r_pc_valid;
    logic        r_flush;
    logic        r_busy;

    logic [31:0] w_pc_plus4;
    logic [5:0]  w_opcode;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_is_jump;
    logic        w_is_branch;
    logic        w_taken;

    // Next-address candidates and instruction decode, all derived from the current pc.
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_opcode        = instr[31:26];
    assign w_jump_target   = {w_pc_plus4[31:28], instr[25:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_is_jump       = instr_valid && ((w_opcode == OP_J) || (w_opcode == OP_JAL));
    assign w_is_branch     = instr_valid && ((w_opcode == OP_BEQ) || (w_opcode == OP_BNE));
    assign w_taken         = r_is_bne ? ~cond_zero : cond_zero;

    // Sequencer FSM: state, pc, latched branch target and all registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every control register has an async reset so the sequencer never
            // wakes up with a stale pending branch or a spurious flush.
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_target   <= 32'd0;
            r_is_bne   <= 1'b0;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let this default be overridden later in
            // the same block without creating ordering hazards between registers.
            r_flush <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (en) begin
                        if (w_is_jump) begin
                            r_pc    <= w_jump_target;
                            r_flush <= 1'b1;
                        end else if (w_is_branch) begin
                            r_target   <= w_branch_target;
                            r_is_bne   <= (w_opcode == OP_BNE);
                            r_state    <= S_RESOLVE;
                            r_pc_valid <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                S_RESOLVE: begin
                    if (en && cond_valid) begin
                        r_pc       <= w_taken ? r_target : w_pc_plus4;
                        r_flush    <= w_taken;
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;
    assign busy     = r_busy;

`ifdef PC_SEQ_JAL_LINK_EN
    logic        r_link_we;
    logic [31:0] r_link_data;

    // Link write-back: one-cycle strobe on each JAL decision, data held until the next JAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_we   <= 1'b0;
            r_link_data <= 32'd0;
        end else begin
            r_link_we <= 1'b0;
            if ((r_state == S_RUN) && en && w_is_jump && (w_opcode == OP_JAL)) begin
                r_link_we   <= 1'b1;
                r_link_data <= w_pc_plus4;
            end
        end
    end

    assign link_we   = r_link_we;
    assign link_data = r_link_data;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic for pc_sequencer,
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        instr_valid;
    logic [31:0] instr;
    logic        cond_valid;
    logic        cond_zero;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        busy;
`ifdef PC_SEQ_JAL_LINK_EN
    logic        link_we;
    logic [31:0] link_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state: "booting" = the one boot cycle, "pending" = waiting on a branch condition.
    logic        m_booting;
    logic        m_pending;
    logic        m_pend_bne;
    logic [31:0] m_target;
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_link_we;
    logic [31:0] m_link_data;

    pc_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .instr_valid(instr_valid),
        .instr      (instr),
        .cond_valid (cond_valid),
        .cond_zero  (cond_zero),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .busy       (busy)
`ifdef PC_SEQ_JAL_LINK_EN
        ,
        .link_we    (link_we),
        .link_data  (link_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booting   = 1'b1;
        m_pending   = 1'b0;
        m_pend_bne  = 1'b0;
        m_target    = 32'd0;
        m_pc        = RV;
        m_flush     = 1'b0;
        m_link_we   = 1'b0;
        m_link_data = 32'd0;
    endtask

    // Apply the sequencing rules for one clock edge given the inputs currently driven.
    task automatic model_step();
        logic [5:0]  op;
        logic [31:0] seq;
        logic        taken;
        op  = instr[31:26];
        seq = m_pc + 32'd4;
        m_flush   = 1'b0;
        m_link_we = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (en) begin
            if (m_pending) begin
                if (cond_valid) begin
                    taken     = m_pend_bne ? !cond_zero : cond_zero;
                    m_pc      = taken ? m_target : seq;
                    m_flush   = taken;
                    m_pending = 1'b0;
                end
            end else if (instr_valid && (op == 6'd2 || op == 6'd3)) begin
                m_pc    = (seq & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
                m_flush = 1'b1;
`ifdef PC_SEQ_JAL_LINK_EN
                if (op == 6'd3) begin
                    m_link_we   = 1'b1;
                    m_link_data = seq;
                end
`endif
            end else if (instr_valid && (op == 6'd4 || op == 6'd5)) begin
                m_target   = seq + 32'($signed(instr[15:0]) * 4);
                m_pend_bne = (op == 6'd5);
                m_pending  = 1'b1;
            end else begin
                m_pc = seq;
            end
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("pc_valid", {31'd0, pc_valid}, {31'd0, !m_booting && !m_pending});
        check("flush", {31'd0, flush}, {31'd0, m_flush});
        check("busy", {31'd0, busy}, {31'd0, m_pending});
`ifdef PC_SEQ_JAL_LINK_EN
        check("link_we", {31'd0, link_we}, {31'd0, m_link_we});
        check("link_data", link_data, m_link_data);
`endif
    endtask

    // Called at posedge+1; inputs already driven. Advances one edge and compares.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asserts reset between edges, checks the asynchronous effect, releases at posedge+1.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        compare_all();
    endtask

    task automatic drive(input logic e, input logic iv, input logic [31:0] ins,
                         input logic cv, input logic cz);
        en          = e;
        instr_valid = iv;
        instr       = ins;
        cond_valid  = cv;
        cond_zero   = cz;
    endtask

    initial begin
        logic [5:0]  op;
        logic [25:0] low;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot and sequential fetch: 0 (invalid), 0, 4, 8, 12.
        check("boot_pc", pc, 32'h0);
        check("boot_valid", {31'd0, pc_valid}, 32'd0);
        cycle(); check("seq0", pc, 32'h0); check("seq0_valid", {31'd0, pc_valid}, 32'd1);
        cycle(); check("seq1", pc, 32'h4);
        cycle(); check("seq2", pc, 32'h8);
        cycle(); check("seq3", pc, 32'hC);

        // Jump to the top of the first 256 MB region, then step across into the next one.
        drive(1'b1, 1'b1, {6'd2, 26'h3FF_FFFF}, 1'b0, 1'b0);
        cycle(); check("j_far", pc, 32'h0FFF_FFFC);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(); check("cross", pc, 32'h1000_0000);
        cycle();
        cycle(); check("at_1008", pc, 32'h1000_0008);
        drive(1'b1, 1'b1, {6'd2, 26'h000_0040}, 1'b0, 1'b0);
        cycle(); check("j_target", pc, 32'h1000_0100); check("j_flush", {31'd0, flush}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(); check("j_flush_drop", {31'd0, flush}, 32'd0);

        // Flush must drop even when the following cycle is stalled.
        drive(1'b1, 1'b1, {6'd3, 26'h000_0010}, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, {6'd2, 26'h000_0020}, 1'b0, 1'b0);
        cycle(); check("stall_flush", {31'd0, flush}, 32'd0);
        cycle();

        // BEQ at 0x20 with imm -2: stall on missing condition, then taken.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 8; i++) cycle();
        check("at_20", pc, 32'h20);
        drive(1'b1, 1'b1, {6'd4, 10'd0, 16'hFFFE}, 1'b0, 1'b0);
        cycle(); check("beq_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(); check("beq_hold", pc, 32'h20);
        end
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(); check("beq_taken", pc, 32'h1C); check("beq_flush", {31'd0, flush}, 32'd1);
        drive(1'b1, 1'b1, {6'd2, 26'h000_0008}, 1'b0, 1'b0);
        cycle(); check("back_20", pc, 32'h20);
        drive(1'b1, 1'b1, {6'd4, 10'd0, 16'hFFFE}, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(); check("beq_not", pc, 32'h24); check("beq_nflush", {31'd0, flush}, 32'd0);

        // BNE pending, stalled with a taken condition present, then reset abandons it.
        drive(1'b1, 1'b1, {6'd5, 10'd0, 16'h0100}, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(); cycle(); check("bne_frozen", pc, 32'h24);
        do_reset();
        check("rst_pc", pc, RV);
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(); check("no_redirect", pc, RV);
        cycle(); check("after_rst", pc, RV + 32'd4);

        // Wrap: backward branch from 4 lands at 0xFFFF_FFFC... from 0 use imm -2.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b1, {6'd4, 10'd0, 16'hFFFE}, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(); check("wrap_top", pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(); check("wrap_zero", pc, 32'h0);

`ifdef PC_SEQ_JAL_LINK_EN
        // JAL at 0x40 writes link 0x44.
        for (int i = 0; i < 16; i++) cycle();
        drive(1'b1, 1'b1, {6'd3, 26'h000_0100}, 1'b0, 1'b0);
        cycle(); check("jal_we", {31'd0, link_we}, 32'd1); check("jal_link", link_data, 32'h44);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(); check("jal_we_drop", {31'd0, link_we}, 32'd0); check("jal_hold", link_data, 32'h44);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            case ($urandom_range(0, 5))
                0:       op = 6'd2;
                1:       op = 6'd3;
                2:       op = 6'd4;
                3:       op = 6'd5;
                default: op = 6'($urandom_range(0, 63));
            endcase
            low = 26'($urandom);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), {op, low},
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
